// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counting timer with one-shot or periodic expiry.
// A reload register holds the start value. Start copies it into count. RUN then
// subtracts DECR on each enabled cycle. Expiry raises a one-cycle expire pulse,
// then either parks in DONE until acknowledged (one-shot) or reloads (periodic).
`timescale 1ns/1ps

module countdown_timer #(
  parameter int WIDTH       = 5,
  parameter int DECR        = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             en,
  input  logic             abort,
  input  logic             done_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DECR_W = WIDTH'(DECR);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic             AUTO_W = (AUTO_RELOAD != 0) ? 1'b1 : 1'b0;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             expire_r;
  logic             expire_s;
  logic             busy_s;
  logic             done_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: count, reload value and the expire pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= ZERO_W;
      reload_r <= ZERO_W;
      expire_r <= 1'b0;
    end else begin
      count_r  <= count_s;
      reload_r <= reload_s;
      expire_r <= expire_s;
    end
  end

  // Next-state and next-datapath logic. Priority is abort > load > start > decrement.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    expire_s = 1'b0;
    if (abort) begin
      // Abort clears the count but keeps the reload value for a later start.
      state_s = ST_IDLE;
      count_s = ZERO_W;
    end else if (load) begin
      // Load never changes state; a running countdown continues from the new value.
      reload_s = data_in;
      count_s  = data_in;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (reload_r == ZERO_W) begin
              // A zero reload expires immediately without entering RUN.
              expire_s = 1'b1;
              count_s  = ZERO_W;
              state_s  = AUTO_W ? ST_IDLE : ST_DONE;
            end else begin
              count_s = reload_r;
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (en) begin
            if (count_r > DECR_W) begin
              count_s = count_r - DECR_W;
            end else begin
              // Compare-guarded expiry: count saturates instead of wrapping.
              expire_s = 1'b1;
              if (!AUTO_W) begin
                count_s = ZERO_W;
                state_s = ST_DONE;
              end else if (reload_r == ZERO_W) begin
                count_s = ZERO_W;
                state_s = ST_IDLE;
              end else begin
                count_s = reload_r;
                state_s = ST_RUN;
              end
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          // Start is ignored here; acknowledge wins even if start is also high.
          count_s = ZERO_W;
          if (done_ack) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          count_s = ZERO_W;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  assign count  = count_r;
  assign expire = expire_r;
  assign busy   = busy_s;
  assign done   = done_s;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer. Three instances share one stimulus:
// one-shot with DECR=1, one-shot with DECR=3, and periodic with DECR=1.
// Expected outputs are queued as each cycle is driven, then popped and compared after the edge.
`timescale 1ns/1ps

module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] data_in;
  logic       start;
  logic       en;
  logic       abort;
  logic       done_ack;

  logic [4:0] count_a, count_b, count_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       expire_a, expire_b, expire_c;

  typedef struct {
    string      tag;
    int         inst;
    logic [4:0] cnt;
    logic       bsy;
    logic       dne;
    logic       exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  countdown_timer #(.WIDTH(5), .DECR(1), .AUTO_RELOAD(0)) u_one (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .start(start),
    .en(en), .abort(abort), .done_ack(done_ack),
    .count(count_a), .busy(busy_a), .done(done_a), .expire(expire_a)
  );

  countdown_timer #(.WIDTH(5), .DECR(3), .AUTO_RELOAD(0)) u_dec3 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .start(start),
    .en(en), .abort(abort), .done_ack(done_ack),
    .count(count_b), .busy(busy_b), .done(done_b), .expire(expire_b)
  );

  countdown_timer #(.WIDTH(5), .DECR(1), .AUTO_RELOAD(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .start(start),
    .en(en), .abort(abort), .done_ack(done_ack),
    .count(count_c), .busy(busy_c), .done(done_c), .expire(expire_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output of one instance against the given expectation.
  task automatic check_inst(input exp_t e);
    logic [4:0] c;
    logic       b, d, x;
    case (e.inst)
      0:       begin c = count_a; b = busy_a; d = done_a; x = expire_a; end
      1:       begin c = count_b; b = busy_b; d = done_b; x = expire_b; end
      default: begin c = count_c; b = busy_c; d = done_c; x = expire_c; end
    endcase
    check_val({e.tag, ".count"},  int'(c), int'(e.cnt));
    check_val({e.tag, ".busy"},   int'(b), int'(e.bsy));
    check_val({e.tag, ".done"},   int'(d), int'(e.dne));
    check_val({e.tag, ".expire"}, int'(x), int'(e.exp));
  endtask

  // Drive one cycle with the current inputs: queue the expectation, clock, pop and compare.
  task automatic step(input int inst, input string tag, input logic [4:0] c,
                      input logic b, input logic d, input logic x);
    exp_t e;
    e.tag = tag; e.inst = inst; e.cnt = c; e.bsy = b; e.dne = d; e.exp = x;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, ".queue_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_inst(e);
    end
  endtask

  task automatic do_abort(input int inst);
    abort = 1'b1;
    step(inst, "abort", 5'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
  endtask

  initial begin
    exp_t r;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; load = 1'b0; data_in = 5'd0; start = 1'b0;
    en = 1'b0; abort = 1'b0; done_ack = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      r.tag = "reset"; r.inst = i; r.cnt = 5'd0; r.bsy = 1'b0; r.dne = 1'b0; r.exp = 1'b0;
      check_inst(r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot countdown from 5, including DONE handling.
    load = 1'b1; data_in = 5'd5;
    step(0, "t1_load", 5'd5, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step(0, "t1_start", 5'd5, 1'b1, 1'b0, 1'b0);
    start = 1'b0; en = 1'b1;
    for (int v = 4; v >= 1; v--) begin
      step(0, "t1_dec", 5'(v), 1'b1, 1'b0, 1'b0);
    end
    step(0, "t1_expire", 5'd0, 1'b0, 1'b1, 1'b1);
    step(0, "t1_hold", 5'd0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    step(0, "t1_start_in_done", 5'd0, 1'b0, 1'b1, 1'b0);
    done_ack = 1'b1;
    step(0, "t1_ack_with_start", 5'd0, 1'b0, 1'b0, 1'b0);
    done_ack = 1'b0; start = 1'b0;
    step(0, "t1_idle", 5'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;

    // DECR=3: 7,4,1,0 with no wrap.
    do_abort(1);
    load = 1'b1; data_in = 5'd7;
    step(1, "t2_load", 5'd7, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step(1, "t2_start", 5'd7, 1'b1, 1'b0, 1'b0);
    start = 1'b0; en = 1'b1;
    step(1, "t2_dec4", 5'd4, 1'b1, 1'b0, 1'b0);
    step(1, "t2_dec1", 5'd1, 1'b1, 1'b0, 1'b0);
    step(1, "t2_expire", 5'd0, 1'b0, 1'b1, 1'b1);
    step(1, "t2_hold", 5'd0, 1'b0, 1'b1, 1'b0);
    en = 1'b0; done_ack = 1'b1;
    step(1, "t2_ack", 5'd0, 1'b0, 1'b0, 1'b0);
    done_ack = 1'b0;

    // Periodic mode: reload 3, ten enabled cycles.
    do_abort(2);
    load = 1'b1; data_in = 5'd3;
    step(2, "t3_load", 5'd3, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step(2, "t3_start", 5'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int m;
      m = i % 3;
      step(2, "t3_periodic", (m == 0) ? 5'd2 : ((m == 1) ? 5'd1 : 5'd3),
           1'b1, 1'b0, (m == 2) ? 1'b1 : 1'b0);
    end
    en = 1'b0;
    do_abort(2);
    load = 1'b1; data_in = 5'd0;
    step(2, "t3_load0", 5'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step(2, "t3_zero_start", 5'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    step(2, "t3_zero_after", 5'd0, 1'b0, 1'b0, 1'b0);

    // Hold with en=0, then reload mid-run.
    do_abort(0);
    load = 1'b1; data_in = 5'd11;
    step(0, "t4_load", 5'd11, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step(0, "t4_start", 5'd11, 1'b1, 1'b0, 1'b0);
    start = 1'b0; en = 1'b1;
    step(0, "t4_dec10", 5'd10, 1'b1, 1'b0, 1'b0);
    step(0, "t4_dec9", 5'd9, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, "t4_hold", 5'd9, 1'b1, 1'b0, 1'b0);
    end
    load = 1'b1; data_in = 5'd20;
    step(0, "t4_reload", 5'd20, 1'b1, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    step(0, "t4_dec19", 5'd19, 1'b1, 1'b0, 1'b0);
    en = 1'b0;

    // Abort beats load and start; reload register keeps 20.
    abort = 1'b1; load = 1'b1; start = 1'b1; data_in = 5'd7;
    step(0, "t5_abort_all", 5'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0; load = 1'b0;
    step(0, "t5_restart", 5'd20, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    do_abort(0);

    // Asynchronous reset mid-run, then start with a zero reload.
    load = 1'b1; data_in = 5'd12;
    step(0, "t6_load", 5'd12, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step(0, "t6_start", 5'd12, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_count", int'(count_a), 0);
    check_val("t6_async_busy", int'(busy_a), 0);
    check_val("t6_async_expire", int'(expire_a), 0);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    step(0, "t6_zero_start", 5'd0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step(0, "t6_zero_done", 5'd0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
